game_status: RTL and testbench
==============================

# game_status

Per-frame game-rules stage for the Pac-Man design. Consumes Pac-Man and ghost positions from the ball and ghost movers, plus pellet-eaten pulses from the renderer. Produces `isGameOver` for `backgroundFSM` and `color_mapper`, plus lives and a 4-digit BCD score for the HEX displays. Collision is evaluated once per video frame; scoring is evaluated every clock.

## Interface
- `HIT_DIST`, 12: collision when both |dX| and |dY| < HIT_DIST (pixels).
- `START_LIVES`, 3: lives loaded at game start (1..3).
- `INVULN_FRAMES`, 60: frames of immunity after a hit (1..255).
- `PELLET_TOTAL`, 240: pellets needed to win (1..1023).
- `EXTRA_LIFE_SCORE`, 100: BCD score threshold for the bonus life (decimal value).

Ports:
- `Clk` in 1: 50 MHz system clock; the only clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `frame_clk` in 1: VGA_VS level, sampled as data (not a clock).
- `playon` in 1: play-screen active.
- `pacX`, `pacY` in 10 each: Pac-Man centre.
- `ghostX[4]`, `ghostY[4]` in 10 each: blue, pink, red, yellow centres.
- `pellet_eaten` in 1: one-`Clk` pulse per pellet consumed.
- `isGameOver` out 1: game ended (loss or win).
- `win` out 1: valid while `isGameOver`=1.
- `lives` out 2: remaining lives.
- `score` out 16: 4 BCD digits, `[15:12]` = thousands.
- `hit_pulse` out 1: one-cycle pulse on a life loss.
- `invuln` out 1: high while in HIT state.

## Operation
- Reset values: `isGameOver`=0, `win`=0, `lives`=START_LIVES, `score`=16'h0000, `hit_pulse`=0, `invuln`=0, state IDLE, pellet count 0.
- Frame tick:
  - `frame_clk` passes through a 2-flop synchroniser, then a rising-edge detector, giving `frame_tick`.
- FSM states: IDLE, PLAY, HIT, OVER.
  - **IDLE**: on `playon` rising, load lives, score, pellet count and win flag with their reset values, then go to PLAY.
  - **PLAY**: on `frame_tick`, if any ghost overlaps Pac-Man:
    - pulse `hit_pulse` and decrement `lives`;
    - if the new lives value is 0, go to OVER with `win`=0;
    - otherwise go to HIT and load the frame counter with INVULN_FRAMES.
  - **HIT**: `invuln`=1 and collisions are ignored. Decrement the frame counter on each `frame_tick`; at 0, return to PLAY.
  - **OVER**: `isGameOver`=1; `score` and `pellet_eaten` are frozen/ignored. On `playon` falling, go to IDLE (`isGameOver` clears).
  - From PLAY or HIT, `playon` falling goes to IDLE and retains score and lives.
- Overlap arithmetic:
  - Differences are 10-bit unsigned absolute values: a≥b ? a−b : b−a.
  - Overlap uses strict `<` on both axes.
  - Multiple ghosts overlapping in the same frame cost exactly one life.
- Scoring:
  - Each `pellet_eaten` in PLAY or HIT adds 1 to the BCD score with per-digit carry, and increments the pellet count.
  - Score saturates at 9999.
  - When the pellet count reaches PELLET_TOTAL: go to OVER with `win`=1, taking priority over a hit in the same cycle.
- Simultaneous events:
  - A pellet and a hit on the same cycle: the pellet is still scored.
  - `Reset_n` low mid-game: the next edge forces all reset values.

## Timing
- `frame_tick` asserts 3 `Clk` cycles after the `frame_clk` rising edge.
- On a hit, `hit_pulse`, `lives` and the state update at the first edge after `frame_tick` (1-cycle latency).
- A pellet updates `score` 1 cycle after the pulse; a digit rollover (0009→0010) is completed in that same cycle.
- `isGameOver` asserts 1 cycle after the deciding event.
- A HIT entered on tick N returns to PLAY on tick N+INVULN_FRAMES.

## Configuration
- `GAME_EXTRA_LIFE_EN` defined:
  - The first time `score` ≥ EXTRA_LIFE_SCORE (BCD compare), `lives` increments by 1, capped at 3.
  - The award is one-shot per game; its flag clears in IDLE.
  - If the award and a hit occur in the same cycle, the net lives change is 0.
- `GAME_EXTRA_LIFE_EN` undefined: no bonus logic is present.

## Structure
- Shared `pacman_pkg` holds:
  - the `game_state_t` enum (IDLE, PLAY, HIT, OVER);
  - the `NUM_GHOSTS`=4 constant;
  - the `bcd4_t` typedef (16 bits).
- Sub-module `bcd_score_counter`: increment enable, saturate at 9999, synchronous active-low clear.
- The overlap comparators stay inline, in a `for` loop over ghosts.

## Test plan
- **Reset**: hold `Reset_n`=0 for 2 cycles → `lives`=3, `score`=0000, `isGameOver`=0, `invuln`=0.
- **Single hit**:
  - Setup: `playon` rising, pac (105,100), blue ghost (100,100), others at (400,400).
  - On the next `frame_tick` → `hit_pulse` for 1 cycle, `lives`=2, `invuln`=1.
  - The overlap is held for 60 frames with no further loss; PLAY resumes at frame 60.
- **Boundary**: pac (112,100), ghost (100,100), HIT_DIST=12 → no hit. Pac (111,100) → hit.
- **Game over**: three separated hits → `lives`=0, `isGameOver`=1, `win`=0. Further pellets are ignored.
- **Scoring**:
  - 12 `pellet_eaten` pulses → `score`=0012; the 0009→0010 rollover is checked on the cycle after the 10th pulse.
  - With `GAME_EXTRA_LIFE_EN` and `lives`=2, reaching 0100 → `lives`=3, awarded once.
- **Win**: PELLET_TOTAL=5, five pulses, with a ghost overlap on the fifth cycle → `isGameOver`=1, `win`=1, no life lost.

Source files
------------

// File: rtl/game_status_pkg.sv
// Shared Pac-Man types: game FSM states, ghost count, 4-digit BCD score type and
// small arithmetic helpers used by the game-rules stage.
package pacman_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int NUM_GHOSTS = 4;

  typedef logic [15:0] bcd4_t;

  function automatic bcd4_t to_bcd4(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/game_status_if.sv
// Position/pellet inputs and status outputs of the game-rules stage.
// master = producer of positions and pellets, slave = game_status.
interface game_status_if;
  import pacman_pkg::*;

  logic                           frame_clk;
  logic                           playon;
  logic [9:0]                     pacX;
  logic [9:0]                     pacY;
  logic [NUM_GHOSTS-1:0][9:0]     ghostX;
  logic [NUM_GHOSTS-1:0][9:0]     ghostY;
  logic                           pellet_eaten;
  logic                           isGameOver;
  logic                           win;
  logic [1:0]                     lives;
  bcd4_t                          score;
  logic                           hit_pulse;
  logic                           invuln;

  modport master (
    output frame_clk, playon, pacX, pacY, ghostX, ghostY, pellet_eaten,
    input  isGameOver, win, lives, score, hit_pulse, invuln
  );

  modport slave (
    input  frame_clk, playon, pacX, pacY, ghostX, ghostY, pellet_eaten,
    output isGameOver, win, lives, score, hit_pulse, invuln
  );

endinterface

// File: rtl/game_status_bcd_score_counter.sv
// 4-digit BCD up-counter with full ripple carry in one cycle, saturating at 9999,
// synchronous active-low clear.
module bcd_score_counter
  import pacman_pkg::*;
(
  input  logic  Clk,
  input  logic  clr_n,
  input  logic  inc_en,
  output bcd4_t count
);

  bcd4_t count_q, count_d;
  logic  carry;

  always_comb begin
    count_d = count_q;
    carry   = inc_en && (count_q != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (count_q[4*d +: 4] == 4'd9) begin
          count_d[4*d +: 4] = 4'd0;
        end else begin
          count_d[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/game_status.sv
// Per-frame game rules: ghost collision, lives, invulnerability window, BCD score, win/loss.
// Optional bonus life enabled by defining GAME_EXTRA_LIFE_EN.
module game_status
  import pacman_pkg::*;
#(
  parameter int HIT_DIST      = 12,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int PELLET_TOTAL  = 240
`ifdef GAME_EXTRA_LIFE_EN
  , parameter int EXTRA_LIFE_SCORE = 100
`endif
)
(
  input logic          Clk,
  input logic          Reset_n,
  game_status_if.slave gif
);

  localparam logic [9:0] HIT_D      = 10'(HIT_DIST);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
  localparam logic [9:0] PEL_TOT    = 10'(PELLET_TOTAL);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

  logic        fc_s1_q, fc_s2_q, fc_s3_q, tick_q, playon_q;
  game_state_t state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic        win_q, win_d, over_q, over_d;
  logic        hit_pulse_q, hit_pulse_d, invuln_q, invuln_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [9:0]  pel_cnt_q, pel_cnt_d;
  logic        any_hit, playon_rise, playon_fall, active, won;
  logic        score_inc, score_clr, award;
  bcd4_t       score;

  assign playon_rise = gif.playon & ~playon_q;
  assign playon_fall = ~gif.playon & playon_q;
  assign active      = (state_q == PLAY) || (state_q == HIT);
  assign won         = gif.pellet_eaten && ((pel_cnt_q + 10'd1) == PEL_TOT);

  always_comb begin
    any_hit = 1'b0;
    for (int g = 0; g < NUM_GHOSTS; g++)
      if (abs_diff10(gif.pacX, gif.ghostX[g]) < HIT_D &&
          abs_diff10(gif.pacY, gif.ghostY[g]) < HIT_D)
        any_hit = 1'b1;
  end

`ifdef GAME_EXTRA_LIFE_EN
  localparam bcd4_t EL_BCD = to_bcd4(EXTRA_LIFE_SCORE);
  logic bonus_q, bonus_d;
  // BCD ordering matches decimal ordering, so a plain compare works.
  assign award = active && !bonus_q && (score >= EL_BCD);
`else
  assign award = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    win_d       = win_q;
    hit_pulse_d = 1'b0;
    fcnt_d      = fcnt_q;
    pel_cnt_d   = pel_cnt_q;
    score_inc   = 1'b0;
    score_clr   = 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
    bonus_d     = bonus_q | award;
`endif
    case (state_q)
      IDLE: if (playon_rise) begin
        state_d   = PLAY;
        lives_d   = LIVES_INIT;
        win_d     = 1'b0;
        pel_cnt_d = '0;
        score_clr = 1'b1;
`ifdef GAME_EXTRA_LIFE_EN
        bonus_d   = 1'b0;
`endif
      end
      PLAY, HIT: begin
        score_inc = gif.pellet_eaten;
        if (gif.pellet_eaten) pel_cnt_d = pel_cnt_q + 10'd1;
        // Win outranks a collision decided on the same edge.
        if (playon_fall) begin
          state_d = IDLE;
        end else if (won) begin
          state_d = OVER;
          win_d   = 1'b1;
        end else if (state_q == PLAY && tick_q && any_hit) begin
          hit_pulse_d = 1'b1;
          lives_d     = lives_q - 2'd1 + {1'b0, award};
          if (lives_q == 2'd1 && !award) begin
            state_d = OVER;
            win_d   = 1'b0;
          end else begin
            state_d = HIT;
            fcnt_d  = INV_LOAD;
          end
        end else if (state_q == HIT && tick_q) begin
          fcnt_d = fcnt_q - 8'd1;
          if (fcnt_q == 8'd1) state_d = PLAY;
        end
        if (award && !hit_pulse_d && lives_q != 2'd3) lives_d = lives_q + 2'd1;
      end
      OVER: if (playon_fall) state_d = IDLE;
    endcase
    over_d   = (state_d == OVER);
    invuln_d = (state_d == HIT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fc_s1_q     <= 1'b0;
      fc_s2_q     <= 1'b0;
      fc_s3_q     <= 1'b0;
      tick_q      <= 1'b0;
      playon_q    <= 1'b0;
      state_q     <= IDLE;
      lives_q     <= LIVES_INIT;
      win_q       <= 1'b0;
      over_q      <= 1'b0;
      hit_pulse_q <= 1'b0;
      invuln_q    <= 1'b0;
      fcnt_q      <= '0;
      pel_cnt_q   <= '0;
`ifdef GAME_EXTRA_LIFE_EN
      bonus_q     <= 1'b0;
`endif
    end else begin
      fc_s1_q     <= gif.frame_clk;
      fc_s2_q     <= fc_s1_q;
      fc_s3_q     <= fc_s2_q;
      tick_q      <= fc_s2_q & ~fc_s3_q;
      playon_q    <= gif.playon;
      state_q     <= state_d;
      lives_q     <= lives_d;
      win_q       <= win_d;
      over_q      <= over_d;
      hit_pulse_q <= hit_pulse_d;
      invuln_q    <= invuln_d;
      fcnt_q      <= fcnt_d;
      pel_cnt_q   <= pel_cnt_d;
`ifdef GAME_EXTRA_LIFE_EN
      bonus_q     <= bonus_d;
`endif
    end
  end

  bcd_score_counter u_score (
    .Clk    (Clk),
    .clr_n  (Reset_n & ~score_clr),
    .inc_en (score_inc),
    .count  (score)
  );

  assign gif.isGameOver = over_q;
  assign gif.win        = win_q;
  assign gif.lives      = lives_q;
  assign gif.score      = score;
  assign gif.hit_pulse  = hit_pulse_q;
  assign gif.invuln     = invuln_q;

endmodule

// File: tb/tb_game_status.sv
// Bench for game_status: a default instance and a PELLET_TOTAL=5 instance, each
// tracked every cycle by a behavioural game model, plus directed literal checks.
module tb_game_status;
  import pacman_pkg::*;

  localparam int INV = 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;

  typedef struct {
    int mode, lives, score, pellets, cnt, win, hp, pp, bonus;
    int h1, h2, h3, h4;
  } mdl_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic fc = 1'b0;
  logic po_a = 1'b0, po_w = 1'b0, pel_a = 1'b0, pel_w = 1'b0;
  logic [9:0] pxa = 10'd200, pya = 10'd200, pxw = 10'd200, pyw = 10'd200;
  logic [NUM_GHOSTS-1:0][9:0] gxa = {4{10'd400}}, gya = {4{10'd400}};
  logic [NUM_GHOSTS-1:0][9:0] gxw = {4{10'd400}}, gyw = {4{10'd400}};

  int checks = 0, errors = 0;
  int hpa_cnt = 0, hpw_cnt = 0;
  bit chk_en = 1'b0;
  mdl_t ma, mw;

  always #5 Clk = ~Clk;

  game_status_if gi ();
  game_status_if gw ();

  assign gi.frame_clk = fc;   assign gw.frame_clk = fc;
  assign gi.playon = po_a;    assign gw.playon = po_w;
  assign gi.pacX = pxa;       assign gw.pacX = pxw;
  assign gi.pacY = pya;       assign gw.pacY = pyw;
  assign gi.ghostX = gxa;     assign gw.ghostX = gxw;
  assign gi.ghostY = gya;     assign gw.ghostY = gyw;
  assign gi.pellet_eaten = pel_a;
  assign gw.pellet_eaten = pel_w;

  game_status u_dut (.Clk(Clk), .Reset_n(Reset_n), .gif(gi));
  game_status #(.PELLET_TOTAL(5)) u_win (.Clk(Clk), .Reset_n(Reset_n), .gif(gw));

  function automatic int to_bcd(int v);
    return (v / 1000 % 10) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10;
  endfunction

  function automatic bit overlap(logic [9:0] px, logic [9:0] py,
                                 logic [NUM_GHOSTS-1:0][9:0] gx, logic [NUM_GHOSTS-1:0][9:0] gy);
    int dx, dy;
    for (int g = 0; g < NUM_GHOSTS; g++) begin
      dx = int'(px) - int'(gx[g]); if (dx < 0) dx = -dx;
      dy = int'(py) - int'(gy[g]); if (dy < 0) dy = -dy;
      if (dx < 12 && dy < 12) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE; m.lives = 3; m.score = 0; m.pellets = 0; m.cnt = 0;
    m.win = 0; m.hp = 0; m.pp = 0; m.bonus = 0;
    m.h1 = 0; m.h2 = 0; m.h3 = 0; m.h4 = 0;
    return m;
  endfunction

  // One Clk edge of the game rules; h1..h4 hold frame_clk as seen 1..4 edges ago.
  function automatic mdl_t mdl_step(mdl_t m, logic rst_n, logic fcv, logic po,
                                    logic pel, bit hit, int ptot);
    mdl_t n;
    bit tick, rise, fall, aw;
    if (!rst_n) return mdl_reset();
    n = m;
    tick = (m.h3 != 0) && (m.h4 == 0);
    n.h4 = m.h3; n.h3 = m.h2; n.h2 = m.h1; n.h1 = int'(fcv);
    rise = po && (m.pp == 0);
    fall = !po && (m.pp != 0);
    n.pp = int'(po);
    n.hp = 0;
    aw = 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
    if ((m.mode == M_PLAY || m.mode == M_HIT) && m.bonus == 0 && m.score >= 100) begin
      aw = 1'b1; n.bonus = 1;
    end
`endif
    if (m.mode == M_IDLE) begin
      if (rise) begin
        n.mode = M_PLAY; n.lives = 3; n.score = 0; n.pellets = 0; n.win = 0; n.bonus = 0;
      end
    end else if (m.mode == M_OVER) begin
      if (fall) n.mode = M_IDLE;
    end else begin
      if (pel) begin
        n.score = (m.score < 9999) ? m.score + 1 : 9999;
        n.pellets = m.pellets + 1;
      end
      if (fall) n.mode = M_IDLE;
      else if (pel && n.pellets == ptot) begin
        n.mode = M_OVER; n.win = 1;
      end else if (m.mode == M_PLAY && tick && hit) begin
        n.hp = 1;
        n.lives = m.lives - 1 + int'(aw);
        if (n.lives == 0) begin n.mode = M_OVER; n.win = 0; end
        else begin n.mode = M_HIT; n.cnt = INV; end
      end else if (m.mode == M_HIT && tick) begin
        n.cnt = m.cnt - 1;
        if (n.cnt == 0) n.mode = M_PLAY;
      end
      if (aw && n.hp == 0 && m.lives < 3) n.lives = m.lives + 1;
    end
    return n;
  endfunction

  always @(posedge Clk) begin
    ma <= mdl_step(ma, Reset_n, fc, po_a, pel_a, overlap(pxa, pya, gxa, gya), 240);
    mw <= mdl_step(mw, Reset_n, fc, po_w, pel_w, overlap(pxw, pyw, gxw, gyw), 5);
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string tag, mdl_t m, logic over, logic w, logic [1:0] lv,
                         bcd4_t sc, logic hp, logic inv);
    chk({tag, ".isGameOver"}, int'(over), (m.mode == M_OVER) ? 1 : 0);
    chk({tag, ".win"},        int'(w),    m.win);
    chk({tag, ".lives"},      int'(lv),   m.lives);
    chk({tag, ".score"},      int'(sc),   to_bcd(m.score));
    chk({tag, ".hit_pulse"},  int'(hp),   m.hp);
    chk({tag, ".invuln"},     int'(inv),  (m.mode == M_HIT) ? 1 : 0);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      cmp_dut("dut", ma, gi.isGameOver, gi.win, gi.lives, gi.score, gi.hit_pulse, gi.invuln);
      cmp_dut("win", mw, gw.isGameOver, gw.win, gw.lives, gw.score, gw.hit_pulse, gw.invuln);
      if (gi.hit_pulse) hpa_cnt <= hpa_cnt + 1;
      if (gw.hit_pulse) hpw_cnt <= hpw_cnt + 1;
    end
  end

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      fc = 1'b1; repeat (5) @(negedge Clk);
      fc = 1'b0; repeat (5) @(negedge Clk);
    end
  endtask

  task automatic pellet_a();
    pel_a = 1'b1; @(negedge Clk);
    pel_a = 1'b0; @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    chk("rst.lives", int'(gi.lives), 3);
    chk("rst.score", int'(gi.score), 'h0000);
    chk("rst.over",  int'(gi.isGameOver), 0);
    chk("rst.inv",   int'(gi.invuln), 0);
    Reset_n = 1'b1;

    // Single hit, then overlap held through the invulnerability window
    pxa = 10'd105; pya = 10'd100; gxa[0] = 10'd100; gya[0] = 10'd100;
    po_a = 1'b1; @(negedge Clk);
    frames(1);
    chk("hit1.pulses", hpa_cnt, 1);
    chk("hit1.lives", int'(gi.lives), 2);
    chk("hit1.inv", int'(gi.invuln), 1);
    frames(59);
    chk("inv59.lives", int'(gi.lives), 2);
    chk("inv59.inv", int'(gi.invuln), 1);
    frames(1);
    chk("inv60.inv", int'(gi.invuln), 0);
    chk("inv60.pulses", hpa_cnt, 1);

    // Distance boundary: 12 misses, 11 hits
    pxa = 10'd112; frames(1);
    chk("bnd12.lives", int'(gi.lives), 2);
    pxa = 10'd111; frames(1);
    chk("bnd11.lives", int'(gi.lives), 1);
    chk("bnd11.inv", int'(gi.invuln), 1);

    // Scoring (while invulnerable) with the 0009 -> 0010 rollover
    for (int i = 1; i <= 12; i++) begin
      pel_a = 1'b1; @(negedge Clk);
      pel_a = 1'b0;
      if (i == 9)  chk("score9", int'(gi.score), 'h0009);
      if (i == 10) chk("score10", int'(gi.score), 'h0010);
      @(negedge Clk);
    end
    chk("score12", int'(gi.score), 'h0012);
    gxa[0] = 10'd400; gya[0] = 10'd400;
    frames(60);
    chk("hit2end.inv", int'(gi.invuln), 0);

    // Third hit ends the game; pellets then ignored
    gxa[0] = 10'd100; gya[0] = 10'd100;
    frames(1);
    chk("over.lives", int'(gi.lives), 0);
    chk("over.over", int'(gi.isGameOver), 1);
    chk("over.win", int'(gi.win), 0);
    repeat (3) pellet_a();
    chk("over.score", int'(gi.score), 'h0012);
    po_a = 1'b0; repeat (2) @(negedge Clk);
    chk("idle.over", int'(gi.isGameOver), 0);

    // Restart, then leave mid-game retaining score
    gxa[0] = 10'd400; gya[0] = 10'd400;
    po_a = 1'b1; repeat (2) @(negedge Clk);
    chk("restart.lives", int'(gi.lives), 3);
    chk("restart.score", int'(gi.score), 'h0000);
    pellet_a();
    po_a = 1'b0; repeat (2) @(negedge Clk);
    chk("leave.score", int'(gi.score), 'h0001);

    // Mid-game reset
    po_a = 1'b1; @(negedge Clk);
    pellet_a();
    Reset_n = 1'b0; @(negedge Clk);
    chk("midrst.score", int'(gi.score), 'h0000);
    chk("midrst.lives", int'(gi.lives), 3);
    Reset_n = 1'b1; @(negedge Clk);

    // Win on the fifth pellet, coinciding with a colliding frame tick
    pxw = 10'd105; pyw = 10'd100;
    po_w = 1'b1; @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      pel_w = 1'b1; @(negedge Clk);
      pel_w = 1'b0; @(negedge Clk);
    end
    chk("win.score4", int'(gw.score), 'h0004);
    fc = 1'b1; repeat (3) @(negedge Clk);
    pel_w = 1'b1; gxw[0] = 10'd100; gyw[0] = 10'd100;
    @(negedge Clk);
    pel_w = 1'b0;
    chk("win.over", int'(gw.isGameOver), 1);
    chk("win.win", int'(gw.win), 1);
    repeat (3) @(negedge Clk);
    fc = 1'b0; repeat (5) @(negedge Clk);
    chk("win.lives", int'(gw.lives), 3);
    chk("win.pulses", hpw_cnt, 0);
    chk("win.score5", int'(gw.score), 'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
